arm_mem_responder: RTL
======================

Name: arm_mem_responder

Overview:
- Memory-side responder for the core's instruction-fetch and data load/store interface.
- Serves both request streams from one single-port word-addressed array, with a fixed, parameterised access latency.
- Returns read data, write acknowledges and a stall indication to the core.
- Data accesses take priority over fetches, and only one access is in flight at a time.

Parameters:
- MEM_WORDS, 4096, array depth in 32-bit words.
- LATENCY, 2, wait cycles before the array access; must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- inst_req  in  1  fetch request; held until inst_valid.
- inst_addr  in  32  fetch byte address.
- inst  out  32  fetched instruction, registered.
- inst_valid  out  1  one-cycle fetch response pulse.
- mem_read_en  in  1  data load request; held until data_valid.
- mem_write_en  in  1  data store request; held until data_valid.
- mem_addr  in  32  data byte address.
- mem_data_in  in  32  store data.
- mem_data_out  out  32  load data, registered.
- data_valid  out  1  one-cycle load-data or store-ack pulse.
- stall  out  1  core must hold its state.
- addr_fault  out  1  pulses together with the valid of an out-of-range access.
- prog_we  in  1  backdoor array write; honoured only while rst=1.
- prog_addr  in  32  backdoor word index.
- prog_data  in  32  backdoor write data.

Behaviour:
- Reset values: all outputs 0 and state IDLE. Reset does not clear the array.
- Backdoor: while rst=1, prog_we=1 writes prog_data to array[prog_addr] at the clock edge. Out-of-range prog_addr is ignored.
- Addressing: word index = addr[31:2]; addr[1:0] is ignored. An index at or above MEM_WORDS is out of range.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read_en or mem_write_en is high, capture address, write data and the write flag, kind=DATA.
  - Otherwise, if inst_req is high, capture inst_addr, kind=INST.
  - On any capture, go to WAIT with cnt=LATENCY-1. With no request, stay in IDLE.
- WAIT:
  - If cnt is not 0, decrement.
  - If cnt is 0, perform the access and go to RESP.
    - Read: the array word is registered into inst or mem_data_out according to kind.
    - Write: array updated.
    - Out of range: a read returns 0 and a write is dropped; the fault flag is registered.
- RESP: assert inst_valid or data_valid (per kind) and addr_fault if flagged, for exactly one cycle. Go to IDLE.
- Latency: a request first sampled in IDLE at cycle T gets its valid in cycle T+LATENCY+1, so 3 cycles at the default.
- Consumption rule: a valid pulse consumes its request. A request still asserted in the cycle after valid is treated as a new request.
- Both streams pending: the data access is served first, and the fetch starts in the IDLE cycle after the data RESP.
- Read and write both asserted: the write wins and the read is not performed.
- Output hold: inst and mem_data_out hold their value until the next read response of the same kind. Write acks do not change mem_data_out.
- stall = (inst_req & ~inst_valid) | ((mem_read_en | mem_write_en) & ~data_valid). It is combinational.
- Request changes mid-flight (address or data alter during WAIT) are ignored; the captured values are used.
- Reset mid-operation: rst=1 in any cycle returns the FSM to IDLE and clears the outputs.
  - A write whose access cycle coincides with rst=1 is not performed.
  - A write already committed before reset stays committed.

Decomposition:
- Shared defines header: FSM state encodings (IDLE, WAIT, RESP) and the request-kind encodings (INST, DATA), alongside the existing CPSR defines.
- Sub-module arm_mem_sram: single-port synchronous RAM with inputs we, word index, wdata and output rdata registered at the edge. The responder owns all sequencing.

Test Plan:
1. Preload via backdoor: array[0x10]=0xE3A01005, then release rst. inst_req=1, inst_addr=0x40 → inst=0xE3A01005 and inst_valid pulses 3 cycles after first sampling. stall=1 in the intervening cycles.
2. Store then load: mem_write_en=1, mem_addr=0x100, mem_data_in=0xDEADBEEF → data_valid ack, mem_data_out unchanged. Then mem_read_en=1, mem_addr=0x100 → mem_data_out=0xDEADBEEF.
3. Simultaneous: inst_req (addr 0x0) and load (addr 0x8) raised in the same cycle → data_valid at T+3, inst_valid at T+7 (data RESP at T+3, fetch sampled in IDLE at T+4, so T+4+3). stall stays 1 until inst_valid.
4. Out of range: load at word index 4096 → data_valid with addr_fault=1 and mem_data_out=0. A store there → ack with addr_fault=1 and the array unchanged.
5. Reset during WAIT of a store to 0x200 (old value 0x11111111) → no valid pulse, all outputs 0, and a subsequent load returns 0x11111111.
6. LATENCY=1 build: a fetch sampled at T gives inst_valid at T+2. Back-to-back fetches each take 3 cycles including the IDLE cycle.

Source files
------------

// File: rtl/arm_mem_responder_pkg.sv
// Shared encodings for the core's memory interface: responder FSM states,
// request kinds and the CPSR field positions used elsewhere in the core.
package arm_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

    typedef enum logic {
        KIND_INST = 1'b0,
        KIND_DATA = 1'b1
    } req_kind_t;

    localparam int unsigned CPSR_N_BIT    = 31;
    localparam int unsigned CPSR_Z_BIT    = 30;
    localparam int unsigned CPSR_C_BIT    = 29;
    localparam int unsigned CPSR_V_BIT    = 28;
    localparam int unsigned CPSR_I_BIT    = 7;
    localparam int unsigned CPSR_F_BIT    = 6;
    localparam int unsigned CPSR_T_BIT    = 5;
    localparam int unsigned CPSR_MODE_LSB = 0;
    localparam int unsigned CPSR_MODE_W   = 5;

    // Byte address to 32-bit word index; the two low bits are ignored.
    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/arm_mem_sram.sv
// Single-port synchronous RAM: write and registered read on the same edge.
module arm_mem_sram #(
    parameter int unsigned WORDS = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule

// File: rtl/arm_mem_responder.sv
// Memory-side responder serving instruction fetches and data loads/stores
// from one single-port array with a fixed access latency.
module arm_mem_responder
    import arm_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_data_out,
    output logic        data_valid,
    output logic        stall,
    output logic        addr_fault,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CW = $clog2(LATENCY + 1);

    mem_state_t  r_state;
    mem_state_t  w_next_state;
    req_kind_t   r_kind;
    logic        r_write;
    logic        r_oor;
    logic [AW-1:0] r_addr;
    logic [31:0] r_wdata;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_inst;
    logic [31:0] r_dout;

    logic        w_data_req;
    logic        w_capture;
    logic        w_access;
    logic [31:0] w_req_addr;
    logic [29:0] w_req_idx;
    logic        w_req_oor;
    logic        w_prog_ok;
    logic        w_ram_we;
    logic [AW-1:0] w_ram_addr;
    logic [31:0] w_ram_wdata;
    logic [31:0] w_ram_rdata;
    logic [31:0] w_rd_word;
    logic        w_inst_rsp;
    logic        w_data_rsp;

    assign w_data_req = mem_read_en | mem_write_en;
    assign w_req_addr = w_data_req ? mem_addr : inst_addr;
    assign w_req_idx  = word_index(w_req_addr);
    assign w_req_oor  = (w_req_idx >= 30'(MEM_WORDS));
    assign w_prog_ok  = (prog_addr < 32'(MEM_WORDS));

    // Backdoor owns the port during reset, which also blocks any in-flight write.
    assign w_ram_we    = rst ? (prog_we & w_prog_ok) : (w_access & r_write & ~r_oor);
    assign w_ram_addr  = rst ? prog_addr[AW-1:0] : r_addr;
    assign w_ram_wdata = rst ? prog_data : r_wdata;

    arm_mem_sram #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

    assign w_rd_word = r_oor ? '0 : w_ram_rdata;

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_access     = 1'b0;
        w_inst_rsp   = 1'b0;
        w_data_rsp   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_data_req | inst_req) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_access     = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_inst_rsp   = (r_kind == KIND_INST);
                w_data_rsp   = (r_kind == KIND_DATA);
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_kind  <= KIND_INST;
            r_write <= 1'b0;
            r_oor   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_inst  <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_kind  <= w_data_req ? KIND_DATA : KIND_INST;
                r_write <= mem_write_en;
                r_oor   <= w_req_oor;
                r_addr  <= w_req_idx[AW-1:0];
                r_wdata <= mem_data_in;
                r_cnt   <= CW'(LATENCY - 1);
            end else if (r_state == ST_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_inst_rsp) begin
                r_inst <= w_rd_word;
            end
            if (w_data_rsp & ~r_write) begin
                r_dout <= w_rd_word;
            end
        end
    end

    // The array's output register presents the read word during RESP; the hold registers take over afterwards.
    assign inst         = w_inst_rsp ? w_rd_word : r_inst;
    assign mem_data_out = (w_data_rsp & ~r_write) ? w_rd_word : r_dout;
    assign inst_valid   = w_inst_rsp;
    assign data_valid   = w_data_rsp;
    assign addr_fault   = (r_state == ST_RESP) & r_oor;
    assign stall        = (inst_req & ~inst_valid) | (w_data_req & ~data_valid);

endmodule
